// File: rtl/key_flag_gen.sv
// Debounced one-shot flag generator for three active-low push-buttons.
// Optional auto-repeat while held: define KEY_REPEAT_EN.
module key_flag_gen #(
  parameter int CNT_MAX    = 1_000_000,
  parameter int HOLD_DLY   = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_in,
  output logic [2:0] flag
);

  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    DOWN,
    REL_FILT
  } state_t;

  logic [2:0] key_m;
  logic [2:0] key_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m <= '1;
      key_s <= '1;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_key
    state_t        st;
    state_t        st_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          acc;
    logic          rpt_hit;
    logic          flag_q;
    logic          ks;

    assign ks = key_s[i];

    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      acc    = 1'b0;
      unique case (st)
        IDLE: begin
          if (!ks) begin
            st_nx  = PRESS_FILT;
            cnt_nx = '0;
          end
        end
        PRESS_FILT: begin
          if (ks) begin
            st_nx  = IDLE;
            cnt_nx = '0;
          end else if (cnt == CNT_LAST) begin
            st_nx = DOWN;
            acc   = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DOWN: begin
          if (ks) begin
            st_nx  = REL_FILT;
            cnt_nx = '0;
          end
        end
        REL_FILT: begin
          if (!ks) begin
            st_nx = DOWN;
          end else if (cnt == CNT_LAST) begin
            st_nx  = IDLE;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          st_nx  = IDLE;
          cnt_nx = '0;
        end
      endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int HMAX = (HOLD_DLY > RPT_PERIOD) ? HOLD_DLY : RPT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_DLY - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(RPT_PERIOD - 1);

    logic [HW-1:0] hcnt;
    logic          rpt;
    logic          hold_tick;

    assign hold_tick = (st == DOWN) && !ks;
    assign rpt_hit   = hold_tick &&
                       (hcnt == (rpt ? RPT_LAST : HOLD_LAST));

    // only a fresh acceptance clears the hold phase; release bounces do not
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt <= '0;
        rpt  <= 1'b0;
      end else if (acc) begin
        hcnt <= '0;
        rpt  <= 1'b0;
      end else if (hold_tick) begin
        if (rpt_hit) begin
          hcnt <= '0;
          rpt  <= 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st     <= IDLE;
        cnt    <= '0;
        flag_q <= 1'b0;
      end else begin
        st     <= st_nx;
        cnt    <= cnt_nx;
        flag_q <= acc | rpt_hit;
      end
    end

    assign flag[i] = flag_q;
  end

endmodule

// File: tb/tb_key_flag_gen.sv
// Directed and random checks of key_flag_gen against a run-length model.
// Define KEY_REPEAT_EN for both files to cover the auto-repeat build.
module tb_key_flag_gen;

  localparam int CNT  = 8;
  localparam int HOLD = 20;
  localparam int RPT  = 10;

`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] key_in;
  logic [2:0] flag;

  key_flag_gen #(
    .CNT_MAX   (CNT),
    .HOLD_DLY  (HOLD),
    .RPT_PERIOD(RPT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_in(key_in),
    .flag  (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tot = 0;
  int bad = 0;
  int cyc = 0;
  int mark = 0;
  int npulse[3];
  int first[3];
  bit saw110;

  // model: synchronizer delay, then low/high run lengths decide acceptance
  bit m_s1[3];
  bit m_s2[3];
  bit m_arm[3];
  bit m_prev[3];
  int m_lo[3];
  int m_hi[3];
  int m_h[3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 1'b1;
      m_s2[i] = 1'b1;
      m_arm[i] = 1'b1;
      m_prev[i] = 1'b1;
      m_lo[i] = 0;
      m_hi[i] = 0;
      m_h[i] = 0;
    end
  endfunction

  function automatic logic [2:0] model_edge();
    logic [2:0] o;
    bit ks;
    bit in_down;
    o = 3'b000;
    if (!rst_n) begin
      model_reset();
      return o;
    end
    for (int i = 0; i < 3; i++) begin
      ks = m_s2[i];
      in_down = !m_arm[i] && !m_prev[i];
      if (!ks) begin
        m_lo[i]++;
        m_hi[i] = 0;
      end else begin
        m_hi[i]++;
        m_lo[i] = 0;
      end
      if (m_arm[i] && m_lo[i] >= CNT + 1) begin
        o[i] = 1'b1;
        m_arm[i] = 1'b0;
        m_h[i] = 0;
      end else if (!m_arm[i] && m_hi[i] >= CNT + 1) begin
        m_arm[i] = 1'b1;
      end else if (REP && in_down && !ks) begin
        m_h[i]++;
        if (m_h[i] >= HOLD && (m_h[i] - HOLD) % RPT == 0)
          o[i] = 1'b1;
      end
      m_prev[i] = ks;
      m_s2[i] = m_s1[i];
      m_s1[i] = key_in[i];
    end
    return o;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [2:0] e;
    int rel;
    @(posedge clk);
    e = model_edge();
    rel = cyc - mark;
    cyc++;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (flag[i] === 1'b1) begin
        npulse[i]++;
        if (first[i] < 0) first[i] = rel;
      end
    end
    if (flag === 3'b110) saw110 = 1'b1;
    chk("flag", 32'(flag), 32'(e));
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic begin_scn();
    mark = cyc;
    saw110 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      npulse[i] = 0;
      first[i] = -1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_in = 3'b111;
    model_reset();
    begin_scn();
    steps(3);
    chk("reset_flag", 32'(flag), 0);
    rst_n = 1'b1;
    steps(5);

    // clean press on key 1
    key_in = 3'b101;
    begin_scn();
    steps(40);
    key_in = 3'b111;
    steps(20);
    chk("clean_first", first[1], 10);
    chk("clean_cnt", npulse[1], REP ? 3 : 1);
    chk("clean_other", npulse[0] + npulse[2], 0);

    // bouncing press on key 0
    for (int r = 0; r < 4; r++) begin
      key_in = 3'b110;
      steps(3);
      key_in = 3'b111;
      steps(2);
    end
    key_in = 3'b110;
    begin_scn();
    steps(30);
    key_in = 3'b111;
    steps(20);
    chk("bounce_first", first[0], 10);
    chk("bounce_cnt", npulse[0], REP ? 2 : 1);

    // short glitch on key 2
    key_in = 3'b011;
    begin_scn();
    steps(5);
    key_in = 3'b111;
    steps(20);
    chk("glitch_cnt", npulse[0] + npulse[1] + npulse[2], 0);

    // keys 1 and 2 together
    key_in = 3'b001;
    begin_scn();
    steps(30);
    key_in = 3'b111;
    steps(20);
    chk("simul_110", 32'(saw110), 1);
    chk("simul_first1", first[1], 10);
    chk("simul_first2", first[2], 10);

    // reset while key 0 is in the press filter (cnt=4 after edge 6)
    key_in = 3'b110;
    begin_scn();
    steps(7);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(flag), 0);
    steps(3);
    chk("rst_none", npulse[0], 0);
    rst_n = 1'b1;
    begin_scn();
    steps(20);
    key_in = 3'b111;
    steps(20);
    chk("rst_first", first[0], 10);
    chk("rst_cnt", npulse[0], 1);

`ifdef KEY_REPEAT_EN
    key_in = 3'b101;
    begin_scn();
    steps(60);
    key_in = 3'b111;
    steps(30);
    chk("rpt_first", first[1], 10);
    chk("rpt_cnt", npulse[1], 5);
`endif

    // random key activity with occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 7) == 0) key_in[i] = ~key_in[i];
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
